pipeline_stall_ctrl: RTL
========================

# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage pipelined core. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their write-enables and flushes. It combines three sources into one prioritised control word per cycle: load-use detection, taken-branch flush, and a multi-cycle data-memory wait. It also runs a drain/halt sequence and a memory-timeout fault trap.

## Interface
- MEM_TIMEOUT, 16, max consecutive MEMWAIT cycles before FAULT (≥1)
- DRAIN_CYCLES, 3, bubble cycles issued after halt_req before HALTED (≥1)
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- idex_memread  in  1  ID/EX instruction is a load
- idex_rd  in  5  ID/EX destination register
- ifid_rs1, ifid_rs2  in  5 each  IF/ID source registers
- branch_taken  in  1  EX resolved a taken branch/jump
- exmem_memreq  in  1  MEM stage has an active data access
- mem_ready  in  1  data memory completes access this cycle
- halt_req  in  1  level request to drain and stop fetch
- pc_write, ifid_write, exmem_write  out  1 each  register write-enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  inject bubble into that register
- halted  out  1  pipeline drained and stopped
- mem_timeout  out  1  sticky fault flag
- stall_cycles, flush_count  out  32 each  perf counters (see Configuration)

## Operation
- The load-use hazard is true when idex_memread && idex_rd != 0 && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2).
- Outputs are combinational from state and inputs (Mealy). The default is pc_write = ifid_write = exmem_write = 1 and all flushes = 0.
- **RUN** state. Conditions are checked in priority order:
  - exmem_memreq && !mem_ready: freeze. pc_write, ifid_write and exmem_write are 0, memwb_flush = 1, idex_flush = 0. Go to MEMWAIT with wait_cnt = 1.
  - branch_taken: ifid_flush = idex_flush = 1, pc_write = 1. This overrides load-use and halt_req in the same cycle.
  - load-use: pc_write = ifid_write = 0, idex_flush = 1.
  - halt_req: pc_write = 0, ifid_flush = 1. Go to DRAIN with drain_cnt = DRAIN_CYCLES−1.
- **MEMWAIT** state:
  - If mem_ready = 1, output the RUN-state response for the current inputs (memory term false) and return to RUN.
  - Otherwise freeze as above and increment wait_cnt.
  - When wait_cnt == MEM_TIMEOUT and mem_ready = 0, go to FAULT.
- **DRAIN** state:
  - pc_write = 0, ifid_flush = 1. Memory-wait freeze has priority and holds drain_cnt.
  - A taken branch in DRAIN flushes IF/ID and ID/EX but keeps pc_write = 0.
  - drain_cnt decrements each unfrozen cycle. Go to HALTED when it is 0 in an unfrozen cycle.
- **HALTED** state: pc_write = 0, ifid_flush = 1, halted = 1. When halt_req = 0, go to RUN on the next edge.
- **FAULT** state: all write-enables are 0, all flushes are 1, mem_timeout = 1. The block exits FAULT only by reset.
- wait_cnt is clog2(MEM_TIMEOUT+1) bits wide and never wraps.

## Timing
- Reset asserted, asynchronously and for its full duration:
  - state = RUN, counters = 0.
  - pc_write = ifid_write = exmem_write = 0, and all flushes = 1.
  - halted = 0, mem_timeout = 0, stall_cycles = flush_count = 0.
- Reset deasserted: outputs take their RUN-state defaults in the same cycle. Reset mid-MEMWAIT or mid-DRAIN discards all progress.
- Load-use costs exactly one bubble cycle. In the next cycle the bubbled ID/EX has memread = 0, so the hazard clears.
- A taken branch costs two flushed slots and has zero-cycle response latency.
- The memory freeze lasts N cycles for a mem_ready arriving N cycles after the request. The pipeline advances in the edge where mem_ready = 1.
- A halt takes DRAIN_CYCLES unfrozen cycles, then halted rises on the following edge.
- If mem_ready = 1 in the same cycle the timeout count is reached, the ready wins and the block returns to RUN.

## Configuration
- PIPE_STALL_PERF_EN is the macro that enables the perf counters.
- Defined:
  - stall_cycles increments every cycle in which pc_write = 0 outside reset, HALTED and FAULT.
  - flush_count increments on each branch_taken flush.
  - Both counters are 32-bit and saturate at 0xFFFFFFFF.
- Undefined: both ports exist and are tied to 0. No counter flops are synthesised.

## Test plan
- **Load-use:** idex_memread = 1, idex_rd = 5, ifid_rs2 = 5. Expect exactly one cycle of pc_write = 0, ifid_write = 0, idex_flush = 1. With idex_rd = 0, expect no stall.
- **Memory wait:** exmem_memreq = 1, mem_ready low for 4 cycles then high. Expect 4 frozen cycles with memwb_flush = 1, release in the 5th cycle, and stall_cycles = 4 with the macro on.
- **Timeout:** MEM_TIMEOUT = 16, mem_ready held low. Expect mem_timeout = 1 after 16 wait cycles, sticky through later mem_ready = 1. Reset clears it to 0.
- **Simultaneous branch and load-use:** expect ifid_flush = idex_flush = 1, pc_write = 1, and flush_count = 1.
- **Halt:** pulse halt_req high, with a 2-cycle memory wait injected during DRAIN. Expect halted = 1 after DRAIN_CYCLES + 2 cycles. Deasserting halt_req then restores pc_write = 1 one edge later.
- **Reset mid-MEMWAIT:** assert reset asynchronously. Expect outputs to go to their reset values immediately, and normal RUN defaults after release.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use, branch flush, data-memory wait,
// drain/halt and memory-timeout fault. Define PIPE_STALL_PERF_EN to build the perf counters.
module pipeline_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        branch_taken,
  input  logic        exmem_memreq,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        exmem_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_flush,
  output logic        halted,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_RUN,
    S_MEMWAIT,
    S_DRAIN,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t               state_q, state_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                 load_use;
  logic                 mem_stall;
  logic                 branch_flush;

  assign load_use  = idex_memread && (idex_rd != 5'd0) &&
                     ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
  assign mem_stall = exmem_memreq && !mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_flush  = 1'b0;
    halted       = 1'b0;
    mem_timeout  = 1'b0;
    branch_flush = 1'b0;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    drain_cnt_d  = drain_cnt_q;

    case (state_q)
      S_RUN, S_MEMWAIT: begin
        if (state_q == S_MEMWAIT && !mem_ready) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          exmem_write = 1'b0;
          memwb_flush = 1'b1;
          if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
            state_d = S_FAULT;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else if (state_q == S_RUN && mem_stall) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          exmem_write = 1'b0;
          memwb_flush = 1'b1;
          state_d     = S_MEMWAIT;
          wait_cnt_d  = WAIT_W'(1);
        end else begin
          // A released MEMWAIT gives exactly the RUN response, transitions included.
          state_d    = S_RUN;
          wait_cnt_d = '0;
          if (branch_taken) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            branch_flush = 1'b1;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end else if (halt_req) begin
            pc_write    = 1'b0;
            ifid_flush  = 1'b1;
            state_d     = S_DRAIN;
            drain_cnt_d = DRAIN_W'(DRAIN_CYCLES - 1);
          end
        end
      end

      S_DRAIN: begin
        if (mem_stall) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          exmem_write = 1'b0;
          memwb_flush = 1'b1;
        end else begin
          pc_write   = 1'b0;
          ifid_flush = 1'b1;
          if (branch_taken) begin
            idex_flush   = 1'b1;
            branch_flush = 1'b1;
          end
          if (drain_cnt_q == '0) begin
            state_d = S_HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
          end
        end
      end

      S_HALTED: begin
        pc_write   = 1'b0;
        ifid_flush = 1'b1;
        halted     = 1'b1;
        if (!halt_req) begin
          state_d = S_RUN;
        end
      end

      S_FAULT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        exmem_write = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        memwb_flush = 1'b1;
        mem_timeout = 1'b1;
      end

      default: begin
        state_d = S_RUN;
      end
    endcase

    // Reset is asynchronous, so the outputs must follow it without waiting for an edge.
    if (reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_flush  = 1'b1;
      halted       = 1'b0;
      mem_timeout  = 1'b0;
      branch_flush = 1'b0;
    end
  end

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && state_q != S_HALTED && state_q != S_FAULT && stall_q != '1) begin
        stall_q <= stall_q + 32'd1;
      end
      if (branch_flush && flush_q != '1) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  logic unused_perf;
  assign unused_perf  = branch_flush;
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
